// File: rtl/ball_physics_pkg.sv
// rtl/ball_physics_pkg.sv - shared field geometry, game_state codes and ball FSM states
package ball_physics_pkg;

    localparam int VBUF_W       = 320;
    localparam int VBUF_H       = 240;
    localparam int GROUND_Y     = VBUF_H - 20;
    localparam int BALL_D       = 20;
    localparam int CHAR_W       = 41;
    localparam int CHAR_H       = 42;
    localparam int NET_X        = 158;
    localparam int NET_W        = 4;
    localparam int NET_TOP      = 140;
    localparam int GRAVITY      = 2;
    localparam int VMAX         = 127;
    localparam int HIT_VY       = 96;
    localparam int HIT_VX_MAX   = 64;
    localparam int HIT_COOLDOWN = 8;
    localparam int SERVE_X_NPC  = 40;
    localparam int SERVE_X_PLY  = 260;
    localparam int SERVE_Y      = 40;

    typedef enum logic [1:0] {
        GS_MENU  = 2'd0,
        GS_SERVE = 2'd1,
        GS_PLAY  = 2'd2,
        GS_OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_SCORED = 2'd2
    } ball_state_t;

endpackage

// File: rtl/ball_physics_box_overlap.sv
// rtl/ball_physics_box_overlap.sv - combinational strict AABB overlap test
module box_overlap #(
    parameter int A_W = 20,
    parameter int A_H = 20,
    parameter int B_W = 41,
    parameter int B_H = 42
) (
    input  logic signed [16:0] a_x,
    input  logic signed [16:0] a_y,
    input  logic signed [16:0] b_x,
    input  logic signed [16:0] b_y,
    output logic               hit
);

    assign hit = (a_x < b_x + 17'(B_W)) && (b_x < a_x + 17'(A_W)) &&
                 (a_y < b_y + 17'(B_H)) && (b_y < a_y + 17'(A_H));

endmodule

// File: rtl/ball_physics.sv
// rtl/ball_physics.sv - ball engine: gravity, character hits, net, walls and scoring
module ball_physics
    import ball_physics_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  game_state,
    input  logic [11:0] npc_pos_x,
    input  logic [11:0] npc_pos_y,
    input  logic [11:0] player_pos_x,
    input  logic [11:0] player_pos_y,
    output logic [11:0] ball_pos_x,
    output logic [11:0] ball_pos_y,
    output logic        point_valid,
    output logic        point_winner,
    output logic        serve_side,
    output logic        in_flight
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic signed [16:0] S_GRAV      = 17'(GRAVITY);
    localparam logic signed [16:0] S_VMAX      = 17'(VMAX);
    localparam logic signed [16:0] S_HIT_VY    = 17'(HIT_VY);
    localparam logic signed [16:0] S_HIT_VX    = 17'(HIT_VX_MAX);
    localparam logic signed [16:0] S_BALL_D    = 17'(BALL_D);
    localparam logic signed [16:0] S_BALL_OFS  = 17'(BALL_D / 2);
    localparam logic signed [16:0] S_CHAR_OFS  = 17'(CHAR_W / 2);
    localparam logic signed [16:0] S_NET_X     = 17'(NET_X);
    localparam logic signed [16:0] S_NET_TOP   = 17'(NET_TOP);
    localparam logic signed [16:0] S_NET_MID   = 17'(NET_X + NET_W / 2);
    localparam logic signed [16:0] S_NET_LEFT  = 17'((NET_X - BALL_D) * 16);
    localparam logic signed [16:0] S_NET_RIGHT = 17'((NET_X + NET_W) * 16);
    localparam logic signed [16:0] S_NET_PARK  = 17'((NET_TOP - BALL_D) * 16);
    localparam logic signed [16:0] S_LAND      = 17'(GROUND_Y - BALL_D);
    localparam logic signed [16:0] S_X_MAX     = 17'(VBUF_W - BALL_D);
    localparam logic signed [16:0] S_X_MAX_Q   = 17'((VBUF_W - BALL_D) * 16);
    localparam logic signed [16:0] S_HALF      = 17'(VBUF_W / 2);

    localparam logic [15:0] SERVE_PX_NPC = 16'(SERVE_X_NPC * 16);
    localparam logic [15:0] SERVE_PX_PLY = 16'(SERVE_X_PLY * 16);
    localparam logic [15:0] SERVE_PY     = 16'(SERVE_Y * 16);
    localparam logic [15:0] LAND_PY      = 16'((GROUND_Y - BALL_D) * 16);
    localparam logic [3:0]  COOL_LOAD    = 4'(HIT_COOLDOWN);

    ball_state_t        state, state_next;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [15:0]        px, py;
    logic signed [11:0] vx, vy;
    logic [3:0]         cool_npc, cool_ply;

    logic signed [16:0] vx_s, vy_s, vy_sum, vy_g, nx, ny, nx_pix, ny_pix, px_pix, py_pix;
    logic signed [16:0] npc_x, npc_y, ply_x, ply_y;
    logic signed [16:0] wx, wy, wvx, wvy, dx, lx;
    logic               ov_npc, ov_ply, ov_net, hit_npc, hit_ply, land, land_winner;

    assign tick   = (game_state == GS_PLAY) && (tick_cnt == CNT_LAST);
    assign vx_s   = $signed({{5{vx[11]}}, vx});
    assign vy_s   = $signed({{5{vy[11]}}, vy});
    assign vy_sum = vy_s + S_GRAV;
    assign vy_g   = (vy_sum > S_VMAX) ? S_VMAX : vy_sum;
    assign nx     = $signed({1'b0, px}) + vx_s;
    assign ny     = $signed({1'b0, py}) + vy_g;
    assign nx_pix = nx >>> 4;
    assign ny_pix = ny >>> 4;
    assign px_pix = $signed({1'b0, px}) >>> 4;
    assign py_pix = $signed({1'b0, py}) >>> 4;
    assign npc_x  = $signed({5'b0, npc_pos_x});
    assign npc_y  = $signed({5'b0, npc_pos_y});
    assign ply_x  = $signed({5'b0, player_pos_x});
    assign ply_y  = $signed({5'b0, player_pos_y});

    box_overlap #(.A_W(BALL_D), .A_H(BALL_D), .B_W(CHAR_W), .B_H(CHAR_H)) u_ov_npc (
        .a_x(nx_pix), .a_y(ny_pix), .b_x(npc_x), .b_y(npc_y), .hit(ov_npc)
    );

    box_overlap #(.A_W(BALL_D), .A_H(BALL_D), .B_W(CHAR_W), .B_H(CHAR_H)) u_ov_ply (
        .a_x(nx_pix), .a_y(ny_pix), .b_x(ply_x), .b_y(ply_y), .hit(ov_ply)
    );

    box_overlap #(.A_W(BALL_D), .A_H(BALL_D), .B_W(NET_W), .B_H(GROUND_Y - NET_TOP)) u_ov_net (
        .a_x(nx_pix), .a_y(ny_pix), .b_x(S_NET_X), .b_y(S_NET_TOP), .hit(ov_net)
    );

    // One tick of physics from the current registers; ground outranks everything else.
    always_comb begin
        land    = ny_pix >= S_LAND;
        hit_npc = ov_npc && (cool_npc == 4'd0);
        hit_ply = !hit_npc && ov_ply && (cool_ply == 4'd0);
        wx      = nx;
        wy      = ny;
        wvx     = vx_s;
        wvy     = vy_g;
        dx      = '0;
        if (hit_npc || hit_ply) begin
            dx  = (nx_pix + S_BALL_OFS) - ((hit_npc ? npc_x : ply_x) + S_CHAR_OFS);
            wvy = -S_HIT_VY;
            wvx = dx <<< 2;
            if (wvx > S_HIT_VX)
                wvx = S_HIT_VX;
            else if (wvx < -S_HIT_VX)
                wvx = -S_HIT_VX;
        end else if (ov_net) begin
            if (py_pix + S_BALL_D <= S_NET_TOP) begin
                wvy = -vy_g;
                wy  = S_NET_PARK;
            end else begin
                wvx = -vx_s;
                wx  = (px_pix + S_BALL_OFS < S_NET_MID) ? S_NET_LEFT : S_NET_RIGHT;
            end
        end
        if (wx < 17'sd0) begin
            wx  = '0;
            wvx = (wvx < 17'sd0) ? -wvx : wvx;
        end else if ((wx >>> 4) > S_X_MAX) begin
            wx  = S_X_MAX_Q;
            wvx = (wvx < 17'sd0) ? wvx : -wvx;
        end
        if (wy < 17'sd0) begin
            wy  = '0;
            wvy = (wvy < 17'sd0) ? -wvy : wvy;
        end
        // Landing skips the bounce logic, so clamp x into the field here.
        if (nx < 17'sd0)
            lx = '0;
        else if (nx_pix > S_X_MAX)
            lx = S_X_MAX_Q;
        else
            lx = nx;
        land_winner = ((lx >>> 4) + S_BALL_OFS) < S_HALF;
    end

    always_comb begin
        state_next = state;
        if (game_state == GS_SERVE) begin
            state_next = ST_HOLD;
        end else begin
            case (state)
                ST_HOLD:   if (game_state == GS_PLAY) state_next = ST_FLIGHT;
                ST_FLIGHT: if (tick && land) state_next = ST_SCORED;
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_HOLD;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt     <= '0;
            px           <= SERVE_PX_NPC;
            py           <= SERVE_PY;
            vx           <= '0;
            vy           <= '0;
            cool_npc     <= '0;
            cool_ply     <= '0;
            serve_side   <= 1'b0;
            point_valid  <= 1'b0;
            point_winner <= 1'b0;
            in_flight    <= 1'b0;
        end else begin
            in_flight   <= (state_next == ST_FLIGHT);
            point_valid <= 1'b0;
            if (game_state == GS_PLAY)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            else
                tick_cnt <= '0;

            if ((game_state == GS_SERVE) || (state == ST_HOLD)) begin
                px       <= serve_side ? SERVE_PX_PLY : SERVE_PX_NPC;
                py       <= SERVE_PY;
                vx       <= '0;
                vy       <= '0;
                cool_npc <= '0;
                cool_ply <= '0;
            end else if ((state == ST_FLIGHT) && tick) begin
                if (land) begin
                    px           <= lx[15:0];
                    py           <= LAND_PY;
                    vx           <= '0;
                    vy           <= '0;
                    point_valid  <= 1'b1;
                    point_winner <= land_winner;
                    serve_side   <= land_winner;
                end else begin
                    px       <= wx[15:0];
                    py       <= wy[15:0];
                    vx       <= wvx[11:0];
                    vy       <= wvy[11:0];
                    cool_npc <= hit_npc ? COOL_LOAD : ((cool_npc != 4'd0) ? cool_npc - 4'd1 : 4'd0);
                    cool_ply <= hit_ply ? COOL_LOAD : ((cool_ply != 4'd0) ? cool_ply - 4'd1 : 4'd0);
                end
            end
        end
    end

    assign ball_pos_x = px[15:4];
    assign ball_pos_y = py[15:4];

endmodule

// File: doc/ball_physics.md
Name: ball_physics

Overview:
- Ball engine for the volleyball field: consumes NPC and player positions plus game_state; produces ball_pos_x/ball_pos_y.
- Runs gravity, wall, net and character-hit physics at a fixed tick rate and reports a point when the ball reaches the ground.
- Sits beside npc and the player controller. Its ball position drives the NPC tracker and the renderer.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per physics tick.
- VBUF_W, 320, field width in px.
- GROUND_Y, 220, ground line (VBUF_H-20).
- BALL_D, 20, ball box size in px.
- CHAR_W, 41, character box width.
- CHAR_H, 42, character box height.
- NET_X, 158, net left edge.
- NET_W, 4, net width.
- NET_TOP, 140, net top y.
- GRAVITY, 2, vy increment per tick (1/16 px/tick).
- VMAX, 127, vy saturation (1/16 px/tick).
- HIT_VY, 96, upward speed after a character hit.
- HIT_VX_MAX, 64, |vx| clamp after a hit.
- HIT_COOLDOWN, 8, ticks before the same character can hit again.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- game_state  in  2  0 menu, 1 serve setup, 2 play, 3 game over
- npc_pos_x  in  12  NPC box top-left x
- npc_pos_y  in  12  NPC box top-left y
- player_pos_x  in  12  player box top-left x
- player_pos_y  in  12  player box top-left y
- ball_pos_x  out  12  ball box top-left x, px
- ball_pos_y  out  12  ball box top-left y, px
- point_valid  out  1  one-cycle pulse when the ball lands
- point_winner  out  1  0 NPC, 1 player; valid with point_valid, held afterwards
- serve_side  out  1  0 NPC (left) serves, 1 player (right) serves
- in_flight  out  1  high in FLIGHT

Behaviour:
- Internal state:
  - px, py: 16-bit Q12.4, pixel = [15:4].
  - vx, vy: signed 12-bit, 1/16 px/tick; y grows downward.
  - All outputs registered.
- Reset:
  - state HOLD, serve_side 0, px=40, py=40, vx=vy=0.
  - point_valid 0, point_winner 0, cooldowns 0, tick counter 0.
- Tick counter:
  - counts 0..TICK_DIV-1 only while game_state==2; held at 0 otherwise.
  - tick pulse on wrap. Outputs reflect the update one cycle after the tick.
- game_state==1, any state: next cycle go to HOLD; serve_side kept.
- HOLD:
  - px = serve_side ? 260 : 40; py=40; v=0.
  - go to FLIGHT on the first cycle game_state==2.
- FLIGHT:
  - ball frozen when game_state is 0 or 3; state kept.
  - Per tick, computed in order from the current registers:
    1. vy' = min(vy+GRAVITY, VMAX).
    2. Next position nx = px+vx, ny = py+vy', evaluated in 17-bit signed.
    3. Ground, highest priority: if ny_pix+BALL_D >= GROUND_Y then:
       - py = GROUND_Y-BALL_D.
       - point_winner = (ball centre x < VBUF_W/2); serve_side = point_winner.
       - pulse point_valid; go to SCORED; skip steps 4–6.
    4. Character hit:
       - condition: ball box overlaps a character box (strict inequalities on both axes) and that character's cooldown is 0. NPC is checked first.
       - vy = -HIT_VY.
       - vx = clamp(4*(ball_cx - (char_x+20)), ±HIT_VX_MAX), where ball_cx = nx_pix+10.
       - load that character's cooldown with HIT_COOLDOWN.
       - cooldowns decrement per tick, saturating at 0.
    5. Net overlap (only if no hit):
       - if the previous py_pix+BALL_D <= NET_TOP: vy = -vy', ny = NET_TOP-BALL_D.
       - otherwise: vx = -vx, nx pushed to the side it came from (NET_X-BALL_D or NET_X+NET_W).
    6. Walls:
       - nx<0: nx=0, vx=|vx|.
       - nx_pix+BALL_D > VBUF_W: nx=VBUF_W-BALL_D, vx=-|vx|.
       - ny<0: ny=0, vy=|vy|.
  - Ball box never leaves [0,VBUF_W-BALL_D] × [0,GROUND_Y-BALL_D].
- SCORED: ball frozen at its landing position; exits only via game_state==1 or reset.
- Simultaneous events:
  - reset beats everything.
  - game_state==1 beats a tick in the same cycle.
  - ground beats a hit in the same tick.

Decomposition:
- Shared package:
  - field geometry constants: VBUF_W, VBUF_H, GROUND_Y, NET_*, CHAR_W/H, BALL_D.
  - game_state encodings.
  - the HOLD/FLIGHT/SCORED state enum.
- One natural sub-module: box_overlap, a combinational AABB test instantiated for NPC, player and net.

Test Plan:
- Use TICK_DIV=4 for all scenarios.
- Reset: assert reset 2 cycles -> ball=(40,40), serve_side 0, in_flight 0, point_valid 0.
- Free fall:
  - setup: npc_x=100, player_x=200, game_state=2.
  - required: point_valid on tick 51 (not 50), ball_pos_y=200, point_winner=1, serve_side=1.
- NPC hit:
  - setup: npc=(20,120); free fall from (40,40).
  - required: hit on tick 31 -> vy=-96, vx=+40; no second NPC hit within the next 8 ticks.
- Wall:
  - setup: npc=(45,120); hit gives vx=-60.
  - required: ball_pos_x clamps at 0, then increases; never exceeds 300.
- Net:
  - setup: ball launched rightward below NET_TOP.
  - required: vx sign flips, ball_pos_x ≤ 138.
  - setup: ball descending onto the net top.
  - required: bounces up with ball_pos_y=120.
- Mid-flight interrupts:
  - game_state=1 mid-flight -> next cycle HOLD at the serve position.
  - reset mid-flight -> (40,40), serve_side 0.
  - game_state=3 mid-flight -> position frozen.
